gray_step_arbiter: RTL
======================

Name: gray_step_arbiter

Overview:
- Round-robin controller that shares one 3-bit Gray-code counter between two requesters.
- The counter is external, with a synchronous active-high reset, an enable, a 3-bit Gray value and a sticky overflow flag.
- Per transaction, the block grants one requester, clears the counter, then pulses its enable for the requested number of steps.
- It returns the final Gray value and the wrap status to the owner with a one-cycle Done pulse.

Parameters:
- STEP_W, 4: width of each requester's step-count field; max steps = 2^STEP_W-1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  2  level request per requester; bit i = requester i.
- Steps0  input  STEP_W  step count for requester 0; sampled at grant.
- Steps1  input  STEP_W  step count for requester 1; sampled at grant.
- Gnt  output  2  one-hot owner of the current transaction; 00 when idle.
- Busy  output  1  high whenever state != IDLE.
- Done  output  2  one-cycle completion pulse to the owner.
- Result  output  3  final Gray value; valid only while Done != 0, otherwise 000.
- Wrap  output  1  counter overflow status; valid only while Done != 0, otherwise 0.
- CntReset  output  1  drives the counter's synchronous reset.
- CntEn  output  1  drives the counter's enable.
- CntValue  input  3  counter Gray output.
- CntOverflow  input  1  counter sticky overflow flag.

Behaviour:
- Interface: one clock (Clk). Reset is asynchronous and active-high.
- Reset (async, immediate):
  - state=IDLE, owner=0, remaining=0, LastGnt=1.
  - All outputs 0: Gnt, Busy, Done, Result, Wrap, CntReset, CntEn.
- Registered state: state, owner (1 bit), remaining (STEP_W), LastGnt (1 bit).
- Outputs are Moore-decoded from state/owner only; no input-to-output combinational paths except Result and Wrap, which mirror CntValue and CntOverflow in DONE.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If Req==00: stay in IDLE.
  - If exactly one Req bit is set: grant that requester.
  - If Req==11: grant !LastGnt, so requester 0 wins first after reset.
  - On grant: owner<=i, LastGnt<=i, remaining<=Steps_i, next state CLEAR.
- CLEAR:
  - CntReset=1 and Gnt=onehot(owner) for one cycle; the counter reads 000 with overflow 0 afterwards.
  - Next state is RUN if remaining!=0, else DONE.
- RUN:
  - CntEn=1 every cycle; remaining decrements each cycle.
  - When remaining==1 this cycle, next state is DONE.
  - Exactly Steps_i enable cycles are issued.
- DONE:
  - Done[owner]=1, Gnt held, Result=CntValue, Wrap=CntOverflow for one cycle.
  - Next state IDLE.
- Latency: grant-sampling edge -> Done asserted after N+2 cycles (1 CLEAR + N RUN + DONE cycle); N=0 gives 2 cycles.
- Back-to-back: Req is re-sampled in the IDLE cycle after DONE. A requester still holding Req then is re-granted, subject to round-robin. The minimum gap between transactions is 1 IDLE cycle.
- Req changes mid-transaction, including deassertion, are ignored; the transaction always completes.
- Steps changes after grant are ignored (latched value).
- Wrap semantics: Wrap=1 iff N>=8. After the 8th step the counter returns to 000 and stays sticky.
- Result equals the Gray code of (N mod 8), e.g. N=5 -> 111.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0, no Done issued, and LastGnt returns to 1.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- Defined:
  - Adds output ChkErr (1 bit, reset 0, sticky until Reset) and a 3-bit previous-value register.
  - In the cycle after CLEAR, CntValue must be 000.
  - In each cycle following a RUN cycle, CntValue must differ from the previous value in exactly one bit.
  - Any violation sets ChkErr.
- Undefined: no ChkErr port and no check logic; behaviour otherwise identical.

Test Plan:
- Reset, then Req=01, Steps0=3:
  - CntReset high 1 cycle, CntEn high exactly 3 cycles.
  - Done=01 with Result=010, Wrap=0, on the 5th cycle after grant.
- Req=10, Steps1=8:
  - 8 CntEn cycles.
  - Done=10, Result=000, Wrap=1.
- After reset, Req=11 held, Steps0=1, Steps1=2:
  - Grant order req0, req1, req0, with one IDLE cycle between transactions.
  - Results 001, 011, 001.
- Req=01, Steps0=0:
  - CLEAR then DONE; no CntEn pulses.
  - Done=01 two cycles after grant, Result=000, Wrap=0.
- Req=01, Steps0=10; assert Reset asynchronously during the 4th RUN cycle:
  - All outputs drop to 0 without a clock edge; no Done.
  - After release, Req=11 grants req0.
- With GRAY_STEP_CHECK_EN defined, use a counter model that jumps 001 -> 010:
  - ChkErr rises the cycle after the bad step and stays 1 until Reset.
  - A correct counter keeps ChkErr=0 over 15 steps.

Source files
------------

// File: rtl/gray_step_arbiter.sv
// Round-robin owner of a shared external 3-bit Gray counter: grant, clear, step N times, report.
// Optional GRAY_STEP_CHECK_EN adds a sticky ChkErr monitor of the counter's Gray sequence.
module gray_step_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  output logic [1:0]        Gnt,
  output logic              Busy,
  output logic [1:0]        Done,
  output logic [2:0]        Result,
  output logic              Wrap,
  output logic              CntReset,
  output logic              CntEn,
  input  logic [2:0]        CntValue,
  input  logic              CntOverflow
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic              ChkErr
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_q;
  logic              owner_q;
  logic              last_q;
  logic [STEP_W-1:0] rem_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              busy_q;
  logic              cnt_reset_q;
  logic              cnt_en_q;
  logic              pick;

  // Contention goes to whoever did not win last; last_q resets to 1 so requester 0 wins first.
  assign pick = (Req == 2'b11) ? ~last_q : Req[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rem_q       <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
      cnt_reset_q <= 1'b0;
      cnt_en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req != 2'b00) begin
            owner_q     <= pick;
            last_q      <= pick;
            rem_q       <= pick ? Steps1 : Steps0;
            gnt_q       <= {pick, ~pick};
            busy_q      <= 1'b1;
            cnt_reset_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_reset_q <= 1'b0;
          if (rem_q != '0) begin
            cnt_en_q <= 1'b1;
            state_q  <= RUN;
          end else begin
            done_q  <= {owner_q, ~owner_q};
            state_q <= DONE;
          end
        end
        RUN: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == 1) begin
            cnt_en_q <= 1'b0;
            done_q   <= {owner_q, ~owner_q};
            state_q  <= DONE;
          end
        end
        default: begin
          done_q  <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Gnt      = gnt_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign CntReset = cnt_reset_q;
  assign CntEn    = cnt_en_q;
  // Only the counter readback is combinational, and only while reporting.
  assign Result   = (done_q != 2'b00) ? CntValue : 3'b000;
  assign Wrap     = (done_q != 2'b00) ? CntOverflow : 1'b0;

`ifdef GRAY_STEP_CHECK_EN
  logic       was_clear_q;
  logic       was_run_q;
  logic [2:0] prev_q;
  logic       chk_err_q;
  logic       bad;

  assign bad = (was_clear_q && (CntValue != 3'b000)) ||
               (was_run_q && ($countones(CntValue ^ prev_q) != 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      was_clear_q <= 1'b0;
      was_run_q   <= 1'b0;
      prev_q      <= 3'b000;
      chk_err_q   <= 1'b0;
    end else begin
      was_clear_q <= (state_q == CLEAR);
      was_run_q   <= (state_q == RUN);
      prev_q      <= CntValue;
      if (bad) chk_err_q <= 1'b1;
    end
  end

  assign ChkErr = chk_err_q;
`endif

endmodule
